// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply Wishbone master and the accelerator slave.
package mm_pkg;

    localparam logic [31:0] ACC_WR_ADDR = 32'h3830_0000;
    localparam logic [31:0] ACC_RD_ADDR = 32'h3830_0010;
    localparam int unsigned TMO_W       = 8;

    typedef enum logic [2:0] {
        StIdle,
        StRdSrc,
        StWrAcc,
        StWaitDone,
        StRdAcc,
        StWrDst,
        StFinish,
        StError
    } mm_state_e;

    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/mm_wb_master_if.sv
// Wishbone initiator/target signal bundle.
interface mm_wb_master_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        ack;

    modport master (output cyc, stb, we, sel, adr, wdat, input rdat, ack);
    modport slave  (input cyc, stb, we, sel, adr, wdat, output rdat, ack);
endinterface

// File: rtl/mm_wb_access.sv
// Single-access Wishbone engine: holds stb until ack, forces a one-cycle gap after each
// access, and flags a timeout when stb stays unacknowledged for TIMEOUT cycles.
module mm_wb_access
    import mm_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        timeout,
    mm_wb_master_if.master bus
);

    logic             gap_q;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             stb;

    // The slave counts rising edges of stb, so every access is followed by one idle cycle.
    assign stb     = req & ~gap_q;
    assign done    = stb & bus.ack;
    assign timeout = stb & ~bus.ack & (tmo_q == TMO_W'(TIMEOUT - 1));

    always_comb begin
        tmo_d = '0;
        if (stb && !bus.ack) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_q <= 1'b0;
            tmo_q <= '0;
        end else begin
            gap_q <= done;
            tmo_q <= tmo_d;
        end
    end

    assign bus.cyc  = stb;
    assign bus.stb  = stb;
    assign bus.we   = stb & we;
    assign bus.sel  = stb ? 4'hF : 4'h0;
    assign bus.adr  = stb ? adr : 32'h0;
    assign bus.wdat = (stb && we) ? wdata : 32'h0;
    assign rdata    = bus.rdat;

endmodule

// File: rtl/mm_wb_master.sv
// Phase sequencer: copies N_IN source words into the accelerator, waits for done,
// then copies N_OUT results to the destination region.
module mm_wb_master
    import mm_pkg::*;
#(
    parameter int unsigned N_IN    = 32,
    parameter int unsigned N_OUT   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic [31:0] src_base_i,
    input  logic [31:0] dst_base_i,
    input  logic        acc_done_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    mm_wb_master_if.master wbm
);

    localparam int unsigned NMax = (N_IN > N_OUT) ? N_IN : N_OUT;
    localparam int unsigned IdxW = (NMax > 1) ? $clog2(NMax) : 1;

    mm_state_e        state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [31:0]      hold_q, hold_d;
    logic             err_q, err_d;

    logic             acc_req;
    logic             acc_we;
    logic [31:0]      acc_adr;
    logic [31:0]      acc_rdata;
    logic             xfer_done;
    logic             xfer_tmo;

    mm_wb_access #(
        .TIMEOUT(TIMEOUT)
    ) u_access (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .req     (acc_req),
        .we      (acc_we),
        .adr     (acc_adr),
        .wdata   (hold_q),
        .rdata   (acc_rdata),
        .done    (xfer_done),
        .timeout (xfer_tmo),
        .bus     (wbm)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        src_d   = src_q;
        dst_d   = dst_q;
        hold_d  = hold_q;
        err_d   = err_q;
        acc_req = 1'b0;
        acc_we  = 1'b0;
        acc_adr = 32'h0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    src_d   = src_base_i;
                    dst_d   = dst_base_i;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = StRdSrc;
                end
            end
            StRdSrc: begin
                acc_req = 1'b1;
                acc_adr = word_addr(src_q, 32'(idx_q));
                if (xfer_done) begin
                    hold_d  = acc_rdata;
                    state_d = StWrAcc;
                end
            end
            StWrAcc: begin
                acc_req = 1'b1;
                acc_we  = 1'b1;
                acc_adr = ACC_WR_ADDR;
                if (xfer_done) begin
                    if (idx_q == IdxW'(N_IN - 1)) begin
                        idx_d   = '0;
                        state_d = StWaitDone;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StRdSrc;
                    end
                end
            end
            StWaitDone: begin
                if (acc_done_i) begin
                    state_d = StRdAcc;
                end
            end
            StRdAcc: begin
                acc_req = 1'b1;
                acc_adr = ACC_RD_ADDR;
                if (xfer_done) begin
                    hold_d  = acc_rdata;
                    state_d = StWrDst;
                end
            end
            StWrDst: begin
                acc_req = 1'b1;
                acc_we  = 1'b1;
                acc_adr = word_addr(dst_q, 32'(idx_q));
                if (xfer_done) begin
                    if (idx_q == IdxW'(N_OUT - 1)) begin
                        idx_d   = '0;
                        state_d = StFinish;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StRdAcc;
                    end
                end
            end
            StFinish: state_d = StIdle;
            StError:  state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        // An unacknowledged access aborts the whole job.
        if (xfer_tmo) begin
            err_d   = 1'b1;
            state_d = StError;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            src_q   <= 32'h0;
            dst_q   <= 32'h0;
            hold_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

    assign busy_o = (state_q == StRdSrc) || (state_q == StWrAcc) || (state_q == StWaitDone) ||
                    (state_q == StRdAcc) || (state_q == StWrDst);
    assign done_o = (state_q == StFinish);
    assign err_o  = err_q;

endmodule

// File: tb/tb_mm_wb_master.sv
// Randomised bench for mm_wb_master: memory/accelerator slave model plus an expected
// access list built from the job description, checked every cycle.
module tb_mm_wb_master;
    import mm_pkg::*;

    localparam int N_IN  = 32;
    localparam int N_OUT = 16;
    localparam int TOTAL = 2 * (N_IN + N_OUT);

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b1;
    logic        start  = 1'b0;
    logic [31:0] src_base = 32'h0;
    logic [31:0] dst_base = 32'h0;
    logic        acc_done = 1'b0;
    logic        busy, done, err;

    mm_wb_master_if wbm ();

    mm_wb_master #(
        .N_IN    (N_IN),
        .N_OUT   (N_OUT),
        .TIMEOUT (255)
    ) dut (
        .wb_clk_i   (wb_clk),
        .wb_rst_i   (wb_rst),
        .start_i    (start),
        .src_base_i (src_base),
        .dst_base_i (dst_base),
        .acc_done_i (acc_done),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .wbm        (wbm)
    );

    always #5 wb_clk = ~wb_clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] job_src, job_dst;
    logic [31:0] src_mem [N_IN];
    logic [31:0] results [N_OUT];
    logic [31:0] dst_mem [N_OUT];
    logic [31:0] acc_in [$];
    int          rd_idx = 0;
    int          waits = 0;
    bit          noack_en = 0;
    logic [31:0] noack_adr = 32'h0;
    int          acc_delay = 0;
    logic        exp_we  [TOTAL];
    logic [31:0] exp_adr [TOTAL];
    logic [31:0] exp_dat [TOTAL];
    int          pos = 0;
    int          done_cnt = 0;
    int          stb_run = 0;
    int          last_run = 0;
    int          gap_cnt = 0;
    bit          prev_stb = 0;
    bit          prev_ack = 0;
    bit          tmo_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory + accelerator slave, answering after `waits` wait states.
    initial begin
        int          wcnt;
        logic [31:0] widx;
        wcnt     = 0;
        wbm.ack  = 1'b0;
        wbm.rdat = 32'h0;
        forever begin
            @(posedge wb_clk);
            #1;
            wbm.ack  = 1'b0;
            wbm.rdat = $urandom;
            if (wbm.stb && !wb_rst) begin
                if (noack_en && !wbm.we && wbm.adr == noack_adr) begin
                    wcnt = 0;
                end else if (wcnt >= waits) begin
                    wbm.ack = 1'b1;
                    wcnt    = 0;
                    if (wbm.we) begin
                        if (wbm.adr == ACC_WR_ADDR) begin
                            acc_in.push_back(wbm.wdat);
                        end else begin
                            widx = (wbm.adr - job_dst) >> 2;
                            if (widx < N_OUT) dst_mem[widx] = wbm.wdat;
                        end
                    end else if (wbm.adr == ACC_RD_ADDR) begin
                        wbm.rdat = results[rd_idx % N_OUT];
                        rd_idx++;
                    end else begin
                        widx     = (wbm.adr - job_src) >> 2;
                        wbm.rdat = (widx < N_IN) ? src_mem[widx] : 32'hdead_beef;
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Accelerator raises done a few cycles after receiving all inputs.
    initial begin
        forever begin
            @(posedge wb_clk);
            #1;
            if (!acc_done && acc_in.size() >= N_IN) begin
                if (acc_delay == 0) acc_done = 1'b1;
                else acc_delay--;
            end
        end
    end

    // Per-cycle compare against the expected access list.
    initial begin
        forever begin
            @(negedge wb_clk);
            if (wb_rst) begin
                prev_stb = 0;
                prev_ack = 0;
                stb_run  = 0;
            end else begin
                check("cyc_eq_stb", wbm.cyc, wbm.stb);
                if (prev_ack) check("gap_after_ack", wbm.stb, 1'b0);
                if (wbm.stb) begin
                    stb_run++;
                    check("sel", wbm.sel, 4'hF);
                    if (pos >= TOTAL) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL extra_access: got adr %0h, expected no access", wbm.adr);
                    end else begin
                        check("we", wbm.we, exp_we[pos]);
                        check("adr", wbm.adr, exp_adr[pos]);
                        if (exp_we[pos]) check("wdat", wbm.wdat, exp_dat[pos]);
                        if (!prev_stb && pos > 0 && pos != 2 * N_IN) check("gap_len", gap_cnt, 1);
                        if (pos == 2 * N_IN) check("rd_acc_after_done", acc_done, 1'b1);
                        if (wbm.ack) pos++;
                    end
                    gap_cnt = 0;
                end else begin
                    if (prev_stb) last_run = stb_run;
                    stb_run = 0;
                    gap_cnt++;
                end
                prev_ack = wbm.stb && wbm.ack;
                prev_stb = wbm.stb;
                if (!tmo_mode && pos > 0 && pos < TOTAL) check("busy_mid", busy, 1'b1);
                if (done) begin
                    done_cnt++;
                    check("done_at_end", pos, TOTAL);
                    check("busy_at_done", busy, 1'b0);
                end
                if (!tmo_mode) check("err_low", err, 1'b0);
            end
        end
    end

    task automatic run_job(input int w, input bit fixed_data, input logic [31:0] sb,
                           input logic [31:0] db, input bit tmo, input bit mid_start,
                           input bit mid_rst);
        bit pulsed;
        pulsed  = 0;
        waits   = w;
        job_src = sb;
        job_dst = db;
        for (int i = 0; i < N_IN; i++) src_mem[i] = fixed_data ? 32'(i + 1) : $urandom;
        for (int j = 0; j < N_OUT; j++) begin
            results[j] = fixed_data ? 32'(100 + j) : $urandom;
            dst_mem[j] = 32'hx;
        end
        for (int i = 0; i < N_IN; i++) begin
            exp_we[2*i]    = 1'b0;
            exp_adr[2*i]   = sb + 32'(4 * i);
            exp_dat[2*i]   = 32'h0;
            exp_we[2*i+1]  = 1'b1;
            exp_adr[2*i+1] = ACC_WR_ADDR;
            exp_dat[2*i+1] = src_mem[i];
        end
        for (int j = 0; j < N_OUT; j++) begin
            exp_we[2*N_IN+2*j]    = 1'b0;
            exp_adr[2*N_IN+2*j]   = ACC_RD_ADDR;
            exp_dat[2*N_IN+2*j]   = 32'h0;
            exp_we[2*N_IN+2*j+1]  = 1'b1;
            exp_adr[2*N_IN+2*j+1] = db + 32'(4 * j);
            exp_dat[2*N_IN+2*j+1] = results[j];
        end
        acc_in.delete();
        rd_idx    = 0;
        acc_done  = 1'b0;
        acc_delay = $urandom_range(0, 6);
        pos       = 0;
        done_cnt  = 0;
        noack_en  = tmo;
        noack_adr = sb + 32'd16;

        @(negedge wb_clk);
        #1;
        src_base = sb;
        dst_base = db;
        start    = 1'b1;
        tmo_mode = tmo;
        @(negedge wb_clk);
        #1;
        start    = 1'b0;
        src_base = $urandom;
        dst_base = $urandom;
        check("err_cleared_by_start", err, 1'b0);

        for (int c = 0; c < 4000; c++) begin
            if (done_cnt > 0 || (tmo && err)) break;
            if (mid_start && !pulsed && pos >= 2 * N_IN + 2 && pos % 2 == 0 && wbm.stb) begin
                start    = 1'b1;
                pulsed   = 1;
                src_base = $urandom;
                dst_base = $urandom;
            end else begin
                start = 1'b0;
            end
            if (mid_rst && pos >= 11 && pos % 2 == 1 && wbm.stb) begin
                wb_rst = 1'b1;
                #1;
                check("rst_cyc", wbm.cyc, 1'b0);
                check("rst_stb", wbm.stb, 1'b0);
                check("rst_busy", busy, 1'b0);
                check("rst_adr", wbm.adr, 32'h0);
                pos = 0;
                repeat (2) @(negedge wb_clk);
                #1;
                wb_rst = 1'b0;
                return;
            end
            @(negedge wb_clk);
            #1;
        end
        start = 1'b0;

        if (tmo) begin
            check("tmo_err_set", err, 1'b1);
            check("tmo_stb_cycles", last_run, 255);
            check("tmo_cyc_low", wbm.cyc, 1'b0);
            check("tmo_busy_low", busy, 1'b0);
            check("tmo_no_done", done_cnt, 0);
            repeat (4) @(negedge wb_clk);
            #1;
            check("tmo_err_sticky", err, 1'b1);
            check("tmo_idle_bus", wbm.stb, 1'b0);
        end else begin
            check("job_done", done_cnt, 1);
            repeat (4) @(negedge wb_clk);
            #1;
            check("done_single", done_cnt, 1);
            check("busy_after", busy, 1'b0);
            check("acc_in_count", acc_in.size(), N_IN);
            for (int i = 0; i < N_IN && i < acc_in.size(); i++) check("acc_in_data", acc_in[i], src_mem[i]);
            for (int j = 0; j < N_OUT; j++) check("dst_data", dst_mem[j], results[j]);
        end
    endtask

    initial begin
        int          w;
        logic [31:0] a;
        logic [31:0] b;
        repeat (3) @(negedge wb_clk);
        check("rst_busy0", busy, 1'b0);
        check("rst_done0", done, 1'b0);
        check("rst_err0", err, 1'b0);
        check("rst_cyc0", wbm.cyc, 1'b0);
        check("rst_stb0", wbm.stb, 1'b0);
        check("rst_we0", wbm.we, 1'b0);
        check("rst_sel0", wbm.sel, 4'h0);
        check("rst_adr0", wbm.adr, 32'h0);
        #1;
        wb_rst = 1'b0;
        repeat (2) @(negedge wb_clk);

        // Zero-wait job with known data; pin the model with literals.
        run_job(0, 1, 32'h0000_1000, 32'h0000_2000, 0, 0, 0);
        check("pin_acc_in0", acc_in[0], 32'd1);
        check("pin_acc_in31", acc_in[31], 32'd32);
        check("pin_dst0", dst_mem[0], 32'd100);
        check("pin_dst15", dst_mem[15], 32'd115);
        check("pin_last_adr", exp_adr[TOTAL-1], 32'h0000_203C);

        // Three wait states; destination wraps past 2^32.
        run_job(3, 0, 32'h0004_0000, 32'hFFFF_FFE0, 0, 0, 0);

        // Fifth source read never acknowledged, then a clean restart.
        run_job(0, 0, 32'h0000_3000, 32'h0000_4000, 1, 0, 0);
        run_job(1, 0, 32'h0000_3000, 32'h0000_4000, 0, 0, 0);

        // Start pulse while reading accelerator results is ignored.
        run_job(2, 0, 32'h0000_5000, 32'h0000_6000, 0, 1, 0);

        // Reset mid write to the accelerator, then restart from src+0.
        run_job(3, 0, 32'h0000_7000, 32'h0000_8000, 0, 0, 1);
        run_job(0, 0, 32'h0000_7000, 32'h0000_8000, 0, 0, 0);

        for (int k = 0; k < 3; k++) begin
            w = $urandom_range(0, 3);
            a = $urandom & 32'hFFFF_FFFC;
            b = $urandom & 32'hFFFF_FFFC;
            run_job(w, 0, a, b, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
